// File: rtl/hemaia_clock_divider_sequencer_if.sv
// Request channel of the clock divider sequencer.
// Carries one domain-index/divisor request under a valid/ready handshake.
interface hemaia_clock_divider_sequencer_if #(
  parameter int IdxWidth         = 2,
  parameter int MaxDivisionWidth = 4
);
  logic                        req_valid_i;
  logic                        req_ready_o;
  logic [IdxWidth-1:0]         req_domain_i;
  logic [MaxDivisionWidth-1:0] req_divisor_i;

  modport master (
    output req_valid_i,
    output req_domain_i,
    output req_divisor_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_domain_i,
    input  req_divisor_i,
    output req_ready_o
  );
endinterface

// File: rtl/hemaia_clock_divider_sequencer.sv
// Sequences divisor changes for a set of clock-divider domains:
// assert domain reset, apply divisor, settle, release, report done.
module hemaia_clock_divider_sequencer #(
  parameter int NumDomains       = 4,
  parameter int MaxDivisionWidth = 4,
  parameter int DefaultDivision  = 1,
  parameter int RstCycles        = 4,
  parameter int SettleCycles     = 32,
  parameter int IdxWidth         =
    (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  hemaia_clock_divider_sequencer_if.slave req,
  output logic [NumDomains*MaxDivisionWidth-1:0] divisor_o,
  output logic [NumDomains-1:0] divisor_valid_o,
  output logic [NumDomains-1:0] domain_rst_no,
  output logic [NumDomains-1:0] gated_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int MaxCyc =
    (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
  localparam int CntW =
    (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] RstLoad =
    CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] SetLoad =
    CntW'(SettleCycles - 1);
  localparam logic [IdxWidth:0] NumDom =
    (IdxWidth + 1)'(NumDomains);
  localparam logic [MaxDivisionWidth-1:0] DefDiv =
    MaxDivisionWidth'(DefaultDivision);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ASSERT_RST = 3'd1;
  localparam logic [2:0] APPLY      = 3'd2;
  localparam logic [2:0] SETTLE     = 3'd3;
  localparam logic [2:0] RELEASE    = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  logic [2:0]                  r_state;
  logic [CntW-1:0]             r_cnt;
  logic [IdxWidth-1:0]         r_dom;
  logic [MaxDivisionWidth-1:0] r_div_req;

  logic [NumDomains-1:0][MaxDivisionWidth-1:0] r_div;
  logic [NumDomains-1:0] r_vld;
  logic [NumDomains-1:0] r_rstn;
  logic [NumDomains-1:0] r_gated;
  logic                  r_done;
  logic                  r_err;

  logic                  w_xfer;
  logic                  w_in_range;
  logic [NumDomains-1:0] w_req_sel;
  logic [NumDomains-1:0] w_sel;

  assign req.req_ready_o = (r_state == IDLE);
  assign busy_o          = (r_state != IDLE);
  assign w_xfer     = req.req_valid_i & req.req_ready_o;
  assign w_in_range = {1'b0, req.req_domain_i} < NumDom;

  assign divisor_o       = r_div;
  assign divisor_valid_o = r_vld;
  assign domain_rst_no   = r_rstn;
  assign gated_o         = r_gated;
  assign done_o          = r_done;
  assign err_o           = r_err;

  // One-hot domain selects for the incoming and latched index
  always_comb begin
    w_req_sel = '0;
    w_sel     = '0;
    for (int i = 0; i < NumDomains; i++) begin
      w_req_sel[i] = (req.req_domain_i == IdxWidth'(i));
      w_sel[i]     = (r_dom == IdxWidth'(i));
    end
  end

  // Sequencer state, shared down-counter and request latch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dom     <= '0;
      r_div_req <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_dom     <= req.req_domain_i;
            r_div_req <= req.req_divisor_i;
            if (w_in_range) begin
              r_state <= ASSERT_RST;
              r_cnt   <= RstLoad;
            end else begin
              r_state <= DONE;
              r_cnt   <= '0;
            end
          end
        end
        ASSERT_RST: begin
          if (r_cnt == '0) begin
            r_state <= APPLY;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        APPLY: begin
          r_state <= SETTLE;
          r_cnt   <= SetLoad;
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= RELEASE;
            r_cnt   <= RstLoad;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RELEASE: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Per-domain outputs change only on the target's state-entry edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div   <= {NumDomains{DefDiv}};
      r_vld   <= '0;
      r_rstn  <= '1;
      r_gated <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_vld  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_in_range) begin
              r_rstn <= r_rstn & ~w_req_sel;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        ASSERT_RST: begin
          if (r_cnt == '0) begin
            r_vld <= w_sel;
            for (int i = 0; i < NumDomains; i++) begin
              if (w_sel[i]) begin
                r_div[i]   <= r_div_req;
                r_gated[i] <= (r_div_req == '0);
              end
            end
          end
        end
        RELEASE: begin
          if (r_cnt == '0) begin
            r_done <= 1'b1;
            for (int i = 0; i < NumDomains; i++) begin
              if (w_sel[i]) begin
                r_rstn[i] <= ~r_gated[i];
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hemaia_clock_divider_sequencer.sv
// Randomised bench for the clock divider sequencer.
// Latency-based reference model plus literal pins on key cycles.
module tb_hemaia_clock_divider_sequencer;

  localparam int ND  = 4;
  localparam int W   = 4;
  localparam int IW  = 3;
  localparam int R   = 4;
  localparam int S   = 32;
  localparam int LAT = 2 * R + S + 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [ND*W-1:0] divisor_o;
  logic [ND-1:0]   divisor_valid_o;
  logic [ND-1:0]   domain_rst_no;
  logic [ND-1:0]   gated_o;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  int checks = 0;
  int errors = 0;

  hemaia_clock_divider_sequencer_if #(
    .IdxWidth(IW),
    .MaxDivisionWidth(W)
  ) rq ();

  hemaia_clock_divider_sequencer #(
    .NumDomains(ND),
    .MaxDivisionWidth(W),
    .DefaultDivision(1),
    .RstCycles(R),
    .SettleCycles(S),
    .IdxWidth(IW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .req(rq),
    .divisor_o(divisor_o),
    .divisor_valid_o(divisor_valid_o),
    .domain_rst_no(domain_rst_no),
    .gated_o(gated_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference model: persistent per-domain state plus the
  // cycle offset k of the request in flight (k=1 first cycle
  // after the accepting edge).
  logic [W-1:0] m_div [ND];
  bit           m_gated [ND];
  bit           m_rst [ND];
  bit           m_active;
  int           m_k;
  logic [IW-1:0] m_dom;
  logic [W-1:0]  m_divreq;
  bit           m_err;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) begin
      m_div[i]   = W'(1);
      m_gated[i] = 1'b0;
      m_rst[i]   = 1'b1;
    end
    m_active = 1'b0;
    m_k      = 0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_edge();
    if (m_active) begin
      m_k++;
      if (m_k > (m_err ? 1 : LAT)) m_active = 1'b0;
    end else if (rq.req_valid_i) begin
      m_active = 1'b1;
      m_k      = 1;
      m_dom    = rq.req_domain_i;
      m_divreq = rq.req_divisor_i;
      m_err    = (int'(rq.req_domain_i) >= ND);
    end
    if (m_active && !m_err) begin
      if (m_k == 1) m_rst[m_dom] = 1'b0;
      if (m_k == R + 1) begin
        m_div[m_dom]   = m_divreq;
        m_gated[m_dom] = (m_divreq == '0);
      end
      if (m_k == LAT) m_rst[m_dom] = !m_gated[m_dom];
    end
  endfunction

  task automatic compare();
    logic [ND*W-1:0] ediv;
    logic [ND-1:0] evld, erst, egat;
    bit edone;
    for (int i = 0; i < ND; i++) begin
      ediv[i*W +: W] = m_div[i];
      erst[i] = m_rst[i];
      egat[i] = m_gated[i];
    end
    evld = '0;
    if (m_active && !m_err && m_k == R + 1)
      evld = ND'(1) << m_dom;
    edone = m_active && (m_k == (m_err ? 1 : LAT));
    chk("divisor_o", divisor_o, ediv);
    chk("divisor_valid_o", divisor_valid_o, evld);
    chk("domain_rst_no", domain_rst_no, erst);
    chk("gated_o", gated_o, egat);
    chk("done_o", done_o, edone);
    chk("err_o", err_o, edone && m_err);
    chk("busy_o", busy_o, m_active);
    chk("req_ready_o", rq.req_ready_o, !m_active);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_ni) model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic rnd_data();
    rq.req_domain_i  = IW'($urandom_range(0, 3));
    rq.req_divisor_i = W'($urandom_range(0, 15));
  endtask

  task automatic run_req(input logic [IW-1:0] d,
                         input logic [W-1:0] v,
                         input bit noise,
                         output int kv,
                         output int kd,
                         output bit e);
    int n;
    n = 0;
    while (!rq.req_ready_o && n < 100) begin
      step();
      n++;
    end
    chk("ready_wait", rq.req_ready_o, 1);
    rq.req_valid_i   = 1'b1;
    rq.req_domain_i  = d;
    rq.req_divisor_i = v;
    step();
    if (noise) rnd_data();
    else rq.req_valid_i = 1'b0;
    kv = 0;
    kd = 0;
    e  = 1'b0;
    for (int k = 1; k <= 100 && kd == 0; k++) begin
      if (|divisor_valid_o) kv = k;
      if (done_o) begin
        kd = k;
        e  = err_o;
      end else begin
        step();
        if (noise) rnd_data();
      end
    end
    if (kd == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int kv, kd, n;
    bit e;
    rq.req_valid_i   = 1'b0;
    rq.req_domain_i  = '0;
    rq.req_divisor_i = '0;
    model_reset();
    step();
    step();
    chk("rst_div", divisor_o, 16'h1111);
    chk("rst_rstn", domain_rst_no, 4'hF);
    chk("rst_ready", rq.req_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    step();

    run_req(3'd2, 4'd6, 1'b0, kv, kd, e);
    chk("t2_valid_at", kv, 5);
    chk("t2_done_at", kd, 42);
    chk("t2_err", e, 0);
    chk("t2_div2", divisor_o[11:8], 6);
    chk("t2_rstn_done", domain_rst_no, 4'hF);

    run_req(3'd1, 4'd0, 1'b0, kv, kd, e);
    chk("t3_gated", gated_o, 4'b0010);
    chk("t3_rstn", domain_rst_no, 4'b1101);
    chk("t3_div1", divisor_o[7:4], 0);
    step();
    step();
    chk("t3_rstn_hold", domain_rst_no[1], 0);
    run_req(3'd1, 4'd3, 1'b0, kv, kd, e);
    chk("t3_ungated", gated_o, 4'b0000);
    chk("t3_release", domain_rst_no, 4'hF);

    run_req(3'd5, 4'd9, 1'b0, kv, kd, e);
    chk("t4_done_at", kd, 1);
    chk("t4_err", e, 1);
    chk("t4_no_valid", kv, 0);
    chk("t4_div", divisor_o, 16'h1631);
    chk("t4_rstn", domain_rst_no, 4'hF);

    run_req(3'd3, 4'd9, 1'b1, kv, kd, e);
    chk("t5_done_at", kd, 42);
    chk("t5_div3", divisor_o[15:12], 9);
    rq.req_valid_i   = 1'b1;
    rq.req_domain_i  = 3'd0;
    rq.req_divisor_i = 4'd2;
    step();
    chk("t5_ready_after", rq.req_ready_o, 1);
    step();
    chk("t5_accepted", busy_o, 1);
    rq.req_valid_i = 1'b0;
    n = 0;
    while (!done_o && n < 100) begin
      step();
      n++;
    end
    chk("t5_second_done", done_o, 1);
    chk("t5_div0", divisor_o[3:0], 2);
    step();

    rq.req_valid_i   = 1'b1;
    rq.req_domain_i  = 3'd0;
    rq.req_divisor_i = 4'd7;
    step();
    rq.req_valid_i = 1'b0;
    repeat (20) step();
    chk("t6_in_settle", domain_rst_no[0], 0);
    do_reset();
    chk("t6_div0", divisor_o[3:0], 1);
    chk("t6_rstn0", domain_rst_no[0], 1);
    chk("t6_idle", busy_o, 0);
    repeat (3) begin
      step();
      chk("t6_no_done", done_o, 0);
    end

    for (int c = 0; c < 4000; c++) begin
      rq.req_valid_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        rq.req_domain_i = IW'($urandom_range(4, 7));
      else
        rq.req_domain_i = IW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        rq.req_divisor_i = '0;
      else
        rq.req_divisor_i = W'($urandom_range(0, 15));
      step();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
